// File: rtl/tsmp_rr_arbiter.sv
// tsmp_rr_arbiter: round-robin arbiter merging N_PORT req/ack packet streams onto one registered 134-bit bus
module tsmp_rr_arbiter #(
    parameter int N_PORT        = 4,
    parameter int PTR_W         = 2,
    parameter int MAX_PKT_WORDS = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_PORT-1:0]     iv_req,
    output logic [N_PORT-1:0]     ov_ack,
    input  logic [134*N_PORT-1:0] iv_data,
    input  logic [N_PORT-1:0]     iv_port_en,
    output logic [133:0]          ov_data,
    output logic                  o_data_wr,
    output logic [PTR_W-1:0]      ov_cur_port,
    output logic                  o_timeout,
    output logic [15:0]           ov_timeout_cnt
);
    typedef enum logic [1:0] {IDLE_S, ACK_S, TRANS_S} state_t;
    state_t            state;
    logic [PTR_W-1:0]  last;
    logic [PTR_W-1:0]  pick;
    logic [7:0]        wcnt;
    logic [N_PORT-1:0] elig;
    logic [133:0]      w;
    assign elig = iv_req & iv_port_en;
    // first eligible port after the last granted one; descending scan leaves the nearest winner
    always_comb begin
        pick = '0;
        for (int i = N_PORT; i >= 1; i--)
            for (int k = 0; k < N_PORT; k++)
                if (elig[k] && k == (int'(last) + i) % N_PORT)
                    pick = PTR_W'(k);
    end
    // word currently offered by the port being transferred
    always_comb begin
        w = '0;
        for (int k = 0; k < N_PORT; k++)
            if (ov_cur_port == PTR_W'(k))
                w = iv_data[134*k +: 134];
    end
    // grant / stream / watchdog state machine with registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE_S;
            last           <= PTR_W'(N_PORT - 1);
            wcnt           <= '0;
            ov_ack         <= '0;
            ov_data        <= '0;
            o_data_wr      <= 1'b0;
            ov_cur_port    <= '0;
            o_timeout      <= 1'b0;
            ov_timeout_cnt <= '0;
        end else begin
            ov_ack    <= '0;
            o_timeout <= 1'b0;
            case (state)
                IDLE_S: begin
                    o_data_wr <= 1'b0;
                    ov_data   <= '0;
                    if (|elig) begin
                        ov_ack      <= N_PORT'(1) << pick;
                        ov_cur_port <= pick;
                        last        <= pick;
                        state       <= ACK_S;
                    end
                end
                ACK_S: begin
                    o_data_wr <= 1'b0;
                    wcnt      <= '0;
                    state     <= TRANS_S;
                end
                TRANS_S: begin
                    ov_data   <= w;
                    o_data_wr <= 1'b1;
                    wcnt      <= wcnt + 8'd1;
                    if (w[133:132] == 2'b10) begin
                        state <= IDLE_S;
                    end else if (wcnt == 8'(MAX_PKT_WORDS - 1)) begin
                        ov_data[133:132] <= 2'b10;
                        o_timeout        <= 1'b1;
                        ov_timeout_cnt   <= (ov_timeout_cnt == 16'hFFFF) ? ov_timeout_cnt : ov_timeout_cnt + 16'd1;
                        state            <= IDLE_S;
                    end
                end
                default: state <= IDLE_S;
            endcase
        end
    end
endmodule

// File: tb/tb_tsmp_rr_arbiter.sv
// tb_tsmp_rr_arbiter: table-driven packet grant/stream checks plus watchdog, saturation and reset sequences
module tb_tsmp_rr_arbiter;
    localparam int NP   = 4;
    localparam int MAXW = 8;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [NP-1:0]     iv_req = '0;
    logic [NP-1:0]     ov_ack;
    logic [134*NP-1:0] iv_data = '0;
    logic [NP-1:0]     iv_port_en = 4'hF;
    logic [133:0]      ov_data;
    logic              o_data_wr;
    logic [1:0]        ov_cur_port;
    logic              o_timeout;
    logic [15:0]       ov_timeout_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = '0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] en;
        int         nw;
        bit         nt;
        int         port;
    } vec_t;
    vec_t tbl[15];

    tsmp_rr_arbiter #(.N_PORT(NP), .PTR_W(2), .MAX_PKT_WORDS(MAXW)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .iv_req(iv_req),
        .ov_ack(ov_ack),
        .iv_data(iv_data),
        .iv_port_en(iv_port_en),
        .ov_data(ov_data),
        .o_data_wr(o_data_wr),
        .ov_cur_port(ov_cur_port),
        .o_timeout(o_timeout),
        .ov_timeout_cnt(ov_timeout_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // word k of an n-word packet from port p; nt suppresses the tail marker
    function automatic logic [133:0] mk(input int p, input int k, input int n, input bit nt);
        logic [1:0] t;
        t = (k == 0) ? 2'b01 : (!nt && k == n - 1) ? 2'b10 : 2'b11;
        return {t, 100'(p * 4099 + k * 257 + 3), 32'(32'hC3A50000 + p * 16 + k)};
    endfunction

    // every port offers its own version of word k so a wrong mux select shows up
    task automatic drive(input int k, input int n, input bit nt);
        for (int p = 0; p < NP; p++) iv_data[134*p +: 134] = mk(p, k, n, nt);
    endtask

    task automatic run_pkt(input logic [3:0] req, input logic [3:0] en, input int nw, input bit nt, input int port);
        int          waited;
        logic [133:0] e;
        waited = 0;
        iv_req = req;
        iv_port_en = en;
        do begin
            @(negedge i_clk);
            waited++;
        end while (ov_ack == '0 && waited < 20);
        chk("ack", 134'(ov_ack), 134'(4'(1) << port));
        if (ov_ack == '0) return;
        chk("cur_port", 134'(ov_cur_port), 134'(port));
        chk("gap_wr_idle", 134'(o_data_wr), 134'(0));
        chk("timeout_idle", 134'(o_timeout), 134'(0));
        for (int j = 1; j <= nw + 1; j++) begin
            @(negedge i_clk);
            if (j == 1) begin
                chk("ack_1cyc", 134'(ov_ack), 134'(0));
                chk("gap_wr_ack", 134'(o_data_wr), 134'(0));
            end else begin
                e = mk(port, j - 2, nw, nt);
                if (nt && j - 2 == MAXW - 1) e[133:132] = 2'b10;
                chk("data", ov_data, e);
                chk("wr", 134'(o_data_wr), 134'(1));
                chk("timeout", 134'(o_timeout), 134'(nt && j - 2 == MAXW - 1));
            end
            if (j <= nw) drive(j - 1, nw, nt);
        end
        if (nt && exp_cnt != 16'hFFFF) exp_cnt++;
        chk("timeout_cnt", 134'(ov_timeout_cnt), 134'(exp_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int waited;
        tbl = '{
            '{4'b0100, 4'hF,    3,    1'b0, 2},
            '{4'hF,    4'hF,    2,    1'b0, 3},
            '{4'hF,    4'hF,    2,    1'b0, 0},
            '{4'hF,    4'hF,    2,    1'b0, 1},
            '{4'hF,    4'hF,    2,    1'b0, 2},
            '{4'hF,    4'hF,    2,    1'b0, 3},
            '{4'hF,    4'hF,    2,    1'b0, 0},
            '{4'hF,    4'b1011, 2,    1'b0, 1},
            '{4'hF,    4'b1011, 2,    1'b0, 3},
            '{4'hF,    4'b1011, 2,    1'b0, 0},
            '{4'hF,    4'b1011, 2,    1'b0, 1},
            '{4'hF,    4'b1011, 2,    1'b0, 3},
            '{4'b0010, 4'hF,    MAXW, 1'b1, 1},
            '{4'hF,    4'hF,    2,    1'b0, 2},
            '{4'b0100, 4'hF,    4,    1'b0, 2}
        };
        repeat (2) @(negedge i_clk);
        chk("rst_ack", 134'(ov_ack), 134'(0));
        chk("rst_data", ov_data, 134'(0));
        chk("rst_wr", 134'(o_data_wr), 134'(0));
        chk("rst_cur_port", 134'(ov_cur_port), 134'(0));
        chk("rst_timeout", 134'(o_timeout), 134'(0));
        chk("rst_timeout_cnt", 134'(ov_timeout_cnt), 134'(0));
        i_rst_n = 1'b1;
        for (int i = 0; i < 15; i++) run_pkt(tbl[i].req, tbl[i].en, tbl[i].nw, tbl[i].nt, tbl[i].port);

        // saturation: preload the counter just below its limit, then time out twice
        iv_req = '0;
        @(negedge i_clk);
        force dut.ov_timeout_cnt = 16'hFFFE;
        #1;
        release dut.ov_timeout_cnt;
        exp_cnt = 16'hFFFE;
        run_pkt(4'b0010, 4'hF, MAXW, 1'b1, 1);
        run_pkt(4'b0010, 4'hF, MAXW, 1'b1, 1);

        // reset on the second word of a 5-word packet from port 1
        waited = 0;
        do begin
            @(negedge i_clk);
            waited++;
        end while (ov_ack == '0 && waited < 20);
        chk("rst_pre_ack", 134'(ov_ack), 134'(4'b0010));
        @(negedge i_clk);
        drive(0, 5, 1'b0);
        @(negedge i_clk);
        drive(1, 5, 1'b0);
        chk("rst_pre_wr", 134'(o_data_wr), 134'(1));
        i_rst_n = 1'b0;
        #1;
        chk("arst_ack", 134'(ov_ack), 134'(0));
        chk("arst_data", ov_data, 134'(0));
        chk("arst_wr", 134'(o_data_wr), 134'(0));
        chk("arst_cur_port", 134'(ov_cur_port), 134'(0));
        chk("arst_timeout", 134'(o_timeout), 134'(0));
        chk("arst_timeout_cnt", 134'(ov_timeout_cnt), 134'(0));
        exp_cnt = '0;
        iv_req = 4'hF;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        run_pkt(4'hF, 4'hF, 2, 1'b0, 0);
        run_pkt(4'hF, 4'hF, 2, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
